// File: rtl/lsu_handshake.sv
// lsu_handshake: RISC-V load/store unit over a req/ack memory bus with byte-lane strobes.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses that
// straddle a bus word are split into two beats; otherwise they fault with no bus traffic.
module lsu_handshake #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rdEn,
  input  logic                  wrEn,
  input  logic [2:0]            funct3,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH-1:0]     wrData,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [DWIDTH-1:0]     rdData,
  output logic                  memReq,
  output logic                  memWe,
  output logic [AWIDTH-1:0]     memAddr,
  output logic [DWIDTH-1:0]     memWdata,
  output logic [DWIDTH/8-1:0]   memBe,
  input  logic                  memAck,
  input  logic [DWIDTH-1:0]     memRdata
);

  localparam int unsigned NB   = DWIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d, we_q, we_d;
  logic                busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d, wdhi_q, wdhi_d, beat0_q, beat0_d, rd_q, rd_d;
  logic [NB-1:0]       be_q, be_d, behi_q, behi_d;
  logic [2:0]          f3_q, f3_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic                split_q, split_d;
  logic [WW-1:0]       wait_q, wait_d;

  // request decode
  logic [OFFW-1:0]     off_c;
  logic [3:0]          sz_c;
  logic                mis_c, op_ok_c, legal_c, split_c, tmo_c;
  logic [2*NB-1:0]     mask_base_c, mask_c;
  logic [2*DWIDTH-1:0] wide_c;

  // Shift a (possibly two-beat) read word down to the addressed bytes and extend it.
  function automatic logic [DWIDTH-1:0] load_ext(input logic [2*DWIDTH-1:0] raw,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [2:0] f3);
    logic [2*DWIDTH-1:0] sh;
    logic [DWIDTH-1:0]   keep;
    logic                sbit;
    sh = raw >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   begin keep = DWIDTH'(64'hFF);        sbit = sh[7];  end
      2'b01:   begin keep = DWIDTH'(64'hFFFF);      sbit = sh[15]; end
      2'b10:   begin keep = DWIDTH'(64'hFFFF_FFFF); sbit = sh[31]; end
      default: begin keep = '1;                     sbit = sh[63]; end
    endcase
    sbit = sbit & ~f3[2];
    return (sh[DWIDTH-1:0] & keep) | (sbit ? ~keep : '0);
  endfunction

  // Size, lane offset, legality and split decision for the incoming request.
  always_comb begin
    off_c   = addr[OFFW-1:0];
    sz_c    = 4'd1 << funct3[1:0];
    mis_c   = (off_c & OFFW'(sz_c - 4'd1)) != '0;
    op_ok_c = 1'b0;
    if (rdEn != wrEn) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_ok_c = 1'b1;
        3'b011:  op_ok_c = (DWIDTH == 64);
        3'b110:  op_ok_c = rdEn && (DWIDTH == 64);
        default: op_ok_c = 1'b0;
      endcase
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    legal_c = op_ok_c;
    split_c = mis_c && ((5'(off_c) + 5'(sz_c)) > 5'(NB));
`else
    legal_c = op_ok_c && !mis_c;
    split_c = 1'b0;
`endif
    mask_base_c = '0;
    for (int i = 0; i < 2 * NB; i++) mask_base_c[i] = (i < int'(sz_c));
    mask_c = mask_base_c << off_c;
    wide_c = {{DWIDTH{1'b0}}, wrData} << {off_c, 3'b000};
    tmo_c  = (TIMEOUT != 0) && (wait_q == WW'(TIMEOUT - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wdhi_d  = wdhi_q;
    behi_d  = behi_q;
    beat0_d = beat0_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    split_d = split_q;
    wait_d  = wait_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!legal_c) begin
            state_d = RESP;
            fault_d = 1'b1;
          end else begin
            state_d = ACC0;
            req_d   = 1'b1;
            we_d    = wrEn;
            addr_d  = {addr[AWIDTH-1:OFFW], OFFW'(0)};
            wdata_d = wide_c[DWIDTH-1:0];
            wdhi_d  = wide_c[2*DWIDTH-1:DWIDTH];
            be_d    = mask_c[NB-1:0];
            behi_d  = mask_c[2*NB-1:NB];
            f3_d    = funct3;
            off_d   = off_c;
            split_d = split_c;
            wait_d  = '0;
          end
        end
      end
      ACC0: begin
        if (memAck) begin
          wait_d = '0;
          if (split_q) begin
            state_d = ACC1;
            addr_d  = addr_q + AWIDTH'(NB);
            wdata_d = wdhi_q;
            be_d    = behi_q;
            beat0_d = memRdata;
          end else begin
            state_d = RESP;
            req_d   = 1'b0;
            if (!we_q) rd_d = load_ext({{DWIDTH{1'b0}}, memRdata}, off_q, f3_q);
          end
        end else if (tmo_c) begin
          state_d = RESP;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ACC1: begin
        if (memAck) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (!we_q) rd_d = load_ext({memRdata, beat0_q}, off_q, f3_q);
        end else if (tmo_c) begin
          state_d = RESP;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wdhi_q  <= '0;
      behi_q  <= '0;
      beat0_q <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      split_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wdhi_q  <= wdhi_d;
      behi_q  <= behi_d;
      beat0_q <= beat0_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      split_q <= split_d;
      wait_q  <= wait_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign rdData   = rd_q;
  assign memReq   = req_q;
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign memBe    = be_q;

endmodule
